cordic_iter_core: RTL and testbench

- Iterative CORDIC datapath that initiates lookups into the shared arctan/arctanh angle table and consumes the returned angle.
- Drives the table offset and the system select each cycle, then applies one micro-rotation per cycle.
- Supports circular and hyperbolic systems, each in rotation or vectoring mode.
- Sits between the accelerator register/control layer and the angle LUT.

---
 rtl/cordic_iter_core.sv | 152 +++++++++++++++
 tb/tb_cordic_iter_core.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter_core.sv
// Iterative CORDIC core: one micro-rotation per cycle, circular or hyperbolic,
// rotation or vectoring, with the shift index driven to an external angle table.
module cordic_iter_core #(
  parameter int unsigned p_WIDTH            = 32,
  parameter int unsigned p_ANGLE_ADDR_WIDTH = 5,
  parameter int unsigned p_ITER             = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          system,
  input  logic                          mode,
  input  logic [p_WIDTH-1:0]            x_in,
  input  logic [p_WIDTH-1:0]            y_in,
  input  logic [p_WIDTH-1:0]            z_in,
  output logic                          busy,
  output logic                          done,
  output logic [p_WIDTH-1:0]            x_out,
  output logic [p_WIDTH-1:0]            y_out,
  output logic [p_WIDTH-1:0]            z_out,
  output logic [p_ANGLE_ADDR_WIDTH-1:0] lut_offset,
  output logic                          lut_system,
  input  logic [p_WIDTH-1:0]            lut_angle
);

  localparam int unsigned W      = p_WIDTH;
  localparam int unsigned AW     = p_ANGLE_ADDR_WIDTH;
  localparam int unsigned CNT_W  = $clog2(p_ITER + 2);
  localparam int unsigned M_CIRC = p_ITER;
  localparam int unsigned M_HYP  = p_ITER + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic                  sys_q;
  logic                  mode_q;
  logic signed [W-1:0]   x_q, y_q, z_q;
  logic signed [W-1:0]   x_d, y_d, z_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  rep_q;
  logic                  busy_q;
  logic                  done_q;
  logic [W-1:0]          x_out_q, y_out_q, z_out_q;
  logic [AW-1:0]         lut_offset_q;
  logic                  lut_system_q;

  logic signed [W-1:0]   x_sh_c, y_sh_c;
  logic                  pos_c;
  logic                  repeat_c;
  logic                  last_c;
  logic [AW-1:0]         idx_next_c;

  assign busy       = busy_q;
  assign done       = done_q;
  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign z_out      = z_out_q;
  assign lut_offset = lut_offset_q;
  assign lut_system = lut_system_q;

  // One micro-rotation using the index currently presented to the table.
  always_comb begin
    x_sh_c     = x_q >>> lut_offset_q;
    y_sh_c     = y_q >>> lut_offset_q;
    pos_c      = mode_q ? y_q[W-1] : ~z_q[W-1];
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    if (pos_c) begin
      x_d = sys_q ? (x_q - y_sh_c) : (x_q + y_sh_c);
      y_d = y_q + x_sh_c;
      z_d = z_q - $signed(lut_angle);
    end else begin
      x_d = sys_q ? (x_q + y_sh_c) : (x_q - y_sh_c);
      y_d = y_q - x_sh_c;
      z_d = z_q + $signed(lut_angle);
    end
    // Hyperbolic convergence needs indices 4 and 13 executed twice.
    repeat_c   = ~sys_q & ~rep_q &
                 ((lut_offset_q == AW'(4)) || (lut_offset_q == AW'(13)));
    last_c     = sys_q ? (cnt_q == CNT_W'(M_CIRC - 1)) : (cnt_q == CNT_W'(M_HYP - 1));
    idx_next_c = repeat_c ? lut_offset_q : (lut_offset_q + AW'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sys_q        <= 1'b1;
      mode_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      cnt_q        <= '0;
      rep_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      z_out_q      <= '0;
      lut_offset_q <= '0;
      lut_system_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            x_q          <= $signed(x_in);
            y_q          <= $signed(y_in);
            z_q          <= $signed(z_in);
            sys_q        <= system;
            mode_q       <= mode;
            cnt_q        <= '0;
            rep_q        <= 1'b0;
            lut_offset_q <= system ? AW'(0) : AW'(1);
            lut_system_q <= system;
            busy_q       <= 1'b1;
            state_q      <= ST_RUN;
          end
        end
        ST_RUN: begin
          x_q   <= x_d;
          y_q   <= y_d;
          z_q   <= z_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_c) begin
            x_out_q <= x_d;
            y_out_q <= y_d;
            z_out_q <= z_d;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            lut_offset_q <= idx_next_c;
            rep_q        <= repeat_c;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_core.sv
// Directed bench for cordic_iter_core with an arctan/arctanh table model
// scaled so that 2^31 angle units equal pi radians.
module tb_cordic_iter_core;

  logic        clk;
  logic        rst;
  logic        start;
  logic        system;
  logic        mode;
  logic [31:0] x_in, y_in, z_in;
  logic        busy, done;
  logic [31:0] x_out, y_out, z_out;
  logic [4:0]  lut_offset;
  logic        lut_system;
  logic [31:0] lut_angle;

  logic [31:0] atan_tab  [32];
  logic [31:0] atanh_tab [32];

  int n_vec = 0;
  int n_err = 0;

  int   off_log[$];
  logic sys_log[$];

  cordic_iter_core #(
    .p_WIDTH(32),
    .p_ANGLE_ADDR_WIDTH(5),
    .p_ITER(24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .system(system),
    .mode(mode),
    .x_in(x_in),
    .y_in(y_in),
    .z_in(z_in),
    .busy(busy),
    .done(done),
    .x_out(x_out),
    .y_out(y_out),
    .z_out(z_out),
    .lut_offset(lut_offset),
    .lut_system(lut_system),
    .lut_angle(lut_angle)
  );

  assign lut_angle = lut_system ? atan_tab[lut_offset] : atanh_tab[lut_offset];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  // Returns exp when act is within tol of it, otherwise act, so check_val reports the real value.
  function automatic logic [31:0] near(input logic [31:0] act, input logic [31:0] exp, input int tol);
    longint df;
    df = longint'($signed(act)) - longint'($signed(exp));
    if (df < 0) df = -df;
    return (df <= longint'(tol)) ? exp : act;
  endfunction

  // Straight reference of the micro-rotation equations over an explicit schedule.
  task automatic ref_model(input logic sys, input logic md, input logic [31:0] xi, input logic [31:0] yi,
                           input logic [31:0] zi, output logic [31:0] xo, output logic [31:0] yo,
                           output logic [31:0] zo);
    int sched[$];
    int x, y, z, xs, ys, ang, d;
    x = int'(xi); y = int'(yi); z = int'(zi);
    if (sys) begin
      for (int i = 0; i < 24; i++) sched.push_back(i);
    end else begin
      for (int i = 1; i < 24; i++) begin
        sched.push_back(i);
        if (i == 4 || i == 13) sched.push_back(i);
      end
    end
    foreach (sched[k]) begin
      xs  = x >>> sched[k];
      ys  = y >>> sched[k];
      ang = sys ? int'(atan_tab[sched[k]]) : int'(atanh_tab[sched[k]]);
      if (md) d = (y < 0) ? 1 : -1;
      else    d = (z >= 0) ? 1 : -1;
      if (sys) x = x - d * ys;
      else     x = x + d * ys;
      y = y + d * xs;
      z = z - d * ang;
    end
    xo = 32'(x); yo = 32'(y); zo = 32'(z);
  endtask

  task automatic run_op(input logic sys, input logic md, input logic [31:0] xi, input logic [31:0] yi,
                        input logic [31:0] zi, input int intr_at, output logic [31:0] xo,
                        output logic [31:0] yo, output logic [31:0] zo, output int edges);
    off_log.delete();
    sys_log.delete();
    @(negedge clk);
    system = sys; mode = md; x_in = xi; y_in = yi; z_in = zi; start = 1'b1;
    edges = 0;
    while (edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = 1'b0;
      if (edges == 1) begin
        x_in = 32'hDEADBEEF; y_in = 32'h8000_0001; z_in = 32'h7FFF_0000;
        system = ~sys; mode = ~md;
      end
      if (edges == intr_at) begin
        start = 1'b1;
        x_in = 32'h1234_5678; y_in = 32'hF000_0000; z_in = 32'hE000_0000;
      end
      if (done) break;
      if (busy) begin
        off_log.push_back(int'(lut_offset));
        sys_log.push_back(lut_system);
      end
    end
    start = 1'b0;
    xo = x_out; yo = y_out; zo = z_out;
  endtask

  logic [31:0] rx, ry, rz, ex, ey, ez;
  int          edges, ones, extra;
  real         scale;
  int          hyp_exp[25] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13,
                               14, 15, 16, 17, 18, 19, 20, 21, 22, 23};

  initial begin
    scale = 2147483648.0 / 3.14159265358979;
    for (int i = 0; i < 32; i++) begin
      atan_tab[i]  = 32'($rtoi($atan(1.0 / (2.0 ** i)) * scale + 0.5));
      atanh_tab[i] = (i == 0) ? 32'd0 : 32'($rtoi($atanh(1.0 / (2.0 ** i)) * scale + 0.5));
    end
    rst = 1'b1; start = 1'b0; system = 1'b0; mode = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_x", x_out, 32'd0);
    check_val("rst_y", y_out, 32'd0);
    check_val("rst_z", z_out, 32'd0);
    check_val("rst_off", 32'(lut_offset), 32'd0);
    check_val("rst_lsys", 32'(lut_system), 32'd1);

    // Circular vectoring of (1,1)/16 scale
    run_op(1'b1, 1'b1, 32'h1000_0000, 32'h1000_0000, 32'h0, 0, rx, ry, rz, edges);
    ref_model(1'b1, 1'b1, 32'h1000_0000, 32'h1000_0000, 32'h0, ex, ey, ez);
    check_val("cv_lat", 32'(edges), 32'd25);
    check_val("cv_x", rx, ex);
    check_val("cv_y", ry, ey);
    check_val("cv_z", rz, ez);
    check_val("cv_z_45deg", near(rz, 32'h2000_0000, 256), 32'h2000_0000);
    check_val("cv_y_zero", near(ry, 32'h0, 2048), 32'h0);
    check_val("cv_x_gain", near(rx, 32'd625151465, 4096), 32'd625151465);
    @(negedge clk);
    check_val("cv_done_1cyc", 32'(done), 32'd0);
    check_val("cv_busy_drop", 32'(busy), 32'd0);

    // Circular rotation by 45 degrees
    run_op(1'b1, 1'b0, 32'h4000_0000, 32'h0, 32'h2000_0000, 0, rx, ry, rz, edges);
    ref_model(1'b1, 1'b0, 32'h4000_0000, 32'h0, 32'h2000_0000, ex, ey, ez);
    check_val("cr_lat", 32'(edges), 32'd25);
    check_val("cr_x", rx, ex);
    check_val("cr_y", ry, ey);
    check_val("cr_z", rz, ez);
    check_val("cr_x_gain", near(rx, 32'd1250302935, 4096), 32'd1250302935);
    check_val("cr_y_gain", near(ry, 32'd1250302935, 4096), 32'd1250302935);
    check_val("cr_nrun", 32'(off_log.size()), 32'd24);
    ones = 0;
    foreach (off_log[k]) begin
      check_val($sformatf("cr_off%0d", k), 32'(off_log[k]), 32'(k));
      if (sys_log[k]) ones++;
    end
    check_val("cr_lsys", 32'(ones), 32'd24);

    // Hyperbolic rotation: schedule with repeated indices
    run_op(1'b0, 1'b0, 32'h2000_0000, 32'h0, 32'h0800_0000, 0, rx, ry, rz, edges);
    ref_model(1'b0, 1'b0, 32'h2000_0000, 32'h0, 32'h0800_0000, ex, ey, ez);
    check_val("hr_lat", 32'(edges), 32'd26);
    check_val("hr_x", rx, ex);
    check_val("hr_y", ry, ey);
    check_val("hr_z", rz, ez);
    check_val("hr_z_zero", near(rz, 32'h0, 256), 32'h0);
    check_val("hr_nrun", 32'(off_log.size()), 32'd25);
    ones = 0;
    foreach (off_log[k]) begin
      if (k < 25) check_val($sformatf("hr_off%0d", k), 32'(off_log[k]), 32'(hyp_exp[k]));
      if (sys_log[k]) ones++;
    end
    check_val("hr_lsys", 32'(ones), 32'd0);

    // Hyperbolic vectoring
    run_op(1'b0, 1'b1, 32'h3000_0000, 32'h1000_0000, 32'h0, 0, rx, ry, rz, edges);
    ref_model(1'b0, 1'b1, 32'h3000_0000, 32'h1000_0000, 32'h0, ex, ey, ez);
    check_val("hv_lat", 32'(edges), 32'd26);
    check_val("hv_x", rx, ex);
    check_val("hv_y", ry, ey);
    check_val("hv_z", rz, ez);
    check_val("hv_y_zero", near(ry, 32'h0, 2048), 32'h0);

    // Start pulse while busy must be ignored
    run_op(1'b1, 1'b0, 32'h2000_0000, 32'h1000_0000, 32'h1000_0000, 6, rx, ry, rz, edges);
    ref_model(1'b1, 1'b0, 32'h2000_0000, 32'h1000_0000, 32'h1000_0000, ex, ey, ez);
    check_val("sb_lat", 32'(edges), 32'd25);
    check_val("sb_x", rx, ex);
    check_val("sb_y", ry, ey);
    check_val("sb_z", rz, ez);
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) extra++;
    end
    check_val("sb_one_done", 32'(extra), 32'd0);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    system = 1'b1; mode = 1'b0; x_in = 32'h4000_0000; y_in = 32'h0; z_in = 32'h1000_0000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_val("ar_busy", 32'(busy), 32'd0);
    check_val("ar_done", 32'(done), 32'd0);
    check_val("ar_x", x_out, 32'd0);
    check_val("ar_y", y_out, 32'd0);
    check_val("ar_z", z_out, 32'd0);
    check_val("ar_off", 32'(lut_offset), 32'd0);
    check_val("ar_lsys", 32'(lut_system), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check_val("ar_no_done", 32'(extra), 32'd0);
    run_op(1'b1, 1'b1, 32'h3000_0000, 32'hF000_0000, 32'h0, 0, rx, ry, rz, edges);
    ref_model(1'b1, 1'b1, 32'h3000_0000, 32'hF000_0000, 32'h0, ex, ey, ez);
    check_val("ar_lat", 32'(edges), 32'd25);
    check_val("ar_rx", rx, ex);
    check_val("ar_ry", ry, ey);
    check_val("ar_rz", rz, ez);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
